flash_loader: RTL and testbench
===============================

# flash_loader

Parametrised boot loader that copies a block of SPI NOR flash into RAM over the RAMIO port, then reports completion. It is the next generation of the core's built-in flash copy sequence and sits between the flash pins and RAMIO ahead of CPU start. It adds a start/done/error handshake, a configurable flash source and RAM destination, an SCK divider, optional fast-read (0x0B) mode, and optional write-readback verification.

## Interface
- STARTUP_WAIT, 1_000_000: clock cycles after reset before the loader accepts `start`; 0 means accept on the first cycle after reset.
- FLASH_ADDRESS, 24'h00_0000: first flash byte address read.
- RAM_ADDRESS, 32'h0000_0000: first RAM byte address written; must be 4-aligned.
- TRANSFER_BYTES_NUM, 32'h0010_0000: bytes copied; must be a multiple of 4 and at least 4.
- SCK_DIV, 1: clk cycles per SCK half-period; must be at least 1.
- FAST_READ, 0: 0 selects command 0x03; 1 selects command 0x0B followed by 8 dummy SCK cycles.
- VERIFY, 0: 1 reads back and compares every word after it is written.
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  high after a successful copy; held until the next accepted start.
- error  out  1  high after a verify mismatch; held until the next accepted start.
- error_address  out  32  RAM byte address of the first mismatching word.
- ramio_enable  out  1  RAMIO request.
- ramio_write_type  out  2  2'b11 (word) for writes, 0 otherwise.
- ramio_read_type  out  3  3'b011 (word) for verify reads, 0 otherwise.
- ramio_address  out  32  RAMIO byte address.
- ramio_data_in  out  32  write data.
- ramio_data_out  in  32  read data.
- ramio_data_out_ready  in  1  read data valid.
- ramio_busy  in  1  RAMIO cannot accept or is completing a request.
- flash_clk, flash_mosi, flash_cs  out  1 each  SPI mode 0 master outputs.
- flash_miso  in  1  SPI data from flash.

## Operation
- Reset values:
  - busy=1; done=0; error=0; error_address=0.
  - All ramio_* outputs 0.
  - flash_clk=0, flash_mosi=0, flash_cs=1.
  - State WAIT_POWER with its counter cleared.
- Reset mid-operation: the same values take effect on the next rising edge, whatever the current state. There is no partial-transfer resume.
- WAIT_POWER: counts to STARTUP_WAIT, then goes to IDLE.
- IDLE:
  - busy=0.
  - On `start`: clear done and error, load the word counter, flash_cs=0, go to CMD.
- CMD: shift the command byte out, 8 bits MSB first.
- ADDR: shift FLASH_ADDRESS out, 24 bits MSB first.
- DUMMY: only when FAST_READ=1. Issue 8 SCK cycles with flash_mosi=0.
- READ:
  - Clock in 32 bits, sampling MISO on SCK rising edges.
  - Bytes are assembled little-endian: the first byte received goes to data[7:0], the fourth to data[31:24].
- WR_REQ: when !ramio_busy, drive enable=1, write_type=2'b11, read_type=0, the current address and the data. Go to WR_WAIT.
- WR_WAIT: on the first !ramio_busy sampled at least one cycle after WR_REQ, deassert enable.
  - Next state is VF_REQ if VERIFY=1.
  - Otherwise READ if words remain, or FINISH.
- VF_REQ: when !ramio_busy, drive enable=1, read_type=3'b011, write_type=0, same address. Go to VF_WAIT.
- VF_WAIT: on ramio_data_out_ready, deassert enable and compare the read data with the written word.
  - Mismatch: error=1, error_address=address, flash_cs=1, go to IDLE. No further writes occur.
  - Match: go to READ if words remain, or FINISH.
- FINISH: flash_cs=1, done=1, go to IDLE.
- Address arithmetic: ramio_address steps by 4 per word starting at RAM_ADDRESS. It is a 32-bit counter and wraps modulo 2^32 without an error.
- Word count: exactly TRANSFER_BYTES_NUM/4 words are copied.
- flash_cs stays low for the whole stream, including RAM stalls. The flash read address auto-increments inside the device and is never re-sent.
- `start` asserted while busy is ignored. It is not queued.

## Timing
- SPI mode 0:
  - SCK idles low, and is held low whenever no bit is shifting (including RAM stalls).
  - MOSI changes on the low phase.
  - One bit takes 2*SCK_DIV clk cycles: SCK low for SCK_DIV cycles, then high for SCK_DIV cycles.
- `start` sampled at edge N: flash_cs=0 and busy=1 at edge N+1; the first SCK rising edge comes SCK_DIV cycles later.
- Header length: 32 SPI bits, or 40 with FAST_READ=1.
- Per word: 32 bit-times of 2*SCK_DIV cycles, plus the RAMIO handshake. The handshake is at least 2 cycles for the write, plus at least 2 for the verify read when VERIFY=1.
- done and error assert the same edge busy falls.

## Test plan
- Basic copy:
  - Stimulus: STARTUP_WAIT=10, TRANSFER_BYTES_NUM=16, SCK_DIV=1, FLASH_ADDRESS=0x000100, RAM_ADDRESS=0x40; flash model byte[i]=i&0xFF; pulse start.
  - Response: MOSI carries 0x03, 0x00, 0x01, 0x00. Writes are 0x40←0x03020100, 0x44←0x07060504, 0x48←0x0B0A0908, 0x4C←0x0F0E0D0C. Then done=1, busy=0, flash_cs=1.
- Fast read with divider:
  - Stimulus: FAST_READ=1, SCK_DIV=3.
  - Response: command 0x0B, then 8 dummy SCK cycles with MOSI=0, then the same four writes. Every SCK phase lasts exactly 3 cycles.
- RAM stall:
  - Stimulus: hold ramio_busy=1 for 20 cycles before the second write.
  - Response: ramio_enable does not rise until busy falls. flash_clk holds 0 and flash_cs holds 0 during the stall. Data is unchanged.
- Verify failure:
  - Stimulus: VERIFY=1; RAM model returns 0xDEADBEEF for address 0x48.
  - Response: error=1, error_address=0x48, done=0, flash_cs=1. No write to 0x4C occurs.
- Reset mid-transfer:
  - Stimulus: drive rst_n=0 for 1 cycle during READ of the second word.
  - Response: on the next edge flash_cs=1, ramio_enable=0, busy=1, and the WAIT_POWER count restarts. A new start then completes the basic copy.
- Start rules:
  - Stimulus: pulse start while busy; then pulse start after done.
  - Response: the pulse while busy has no effect. The pulse after done clears done on the next edge and repeats the copy.

Source files
------------

// File: rtl/flash_loader.sv
// flash_loader: after power-up wait, streams a block of SPI NOR flash into RAM over RAMIO,
// with start/done/error handshake and optional per-word readback verification.
module flash_loader #(
    parameter int unsigned STARTUP_WAIT       = 1_000_000,
    parameter logic [23:0] FLASH_ADDRESS      = 24'h00_0000,
    parameter logic [31:0] RAM_ADDRESS        = 32'h0000_0000,
    parameter logic [31:0] TRANSFER_BYTES_NUM = 32'h0010_0000,
    parameter int unsigned SCK_DIV            = 1,
    parameter bit          FAST_READ          = 0,
    parameter bit          VERIFY             = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] error_address,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [2:0]  ramio_read_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic [31:0] ramio_data_out,
    input  logic        ramio_data_out_ready,
    input  logic        ramio_busy,
    output logic        flash_clk,
    output logic        flash_mosi,
    output logic        flash_cs,
    input  logic        flash_miso
);
    typedef enum logic [3:0] {
        WAIT_POWER, IDLE, CMD, ADDR, DUMMY, READ, WR_REQ, WR_WAIT, VF_REQ, VF_WAIT, FINISH
    } state_t;
    localparam logic [7:0]  CMD_BYTE = FAST_READ ? 8'h0B : 8'h03;
    localparam logic [29:0] WORDS    = TRANSFER_BYTES_NUM[31:2];
    state_t      state;
    logic [31:0] wait_cnt, addr, div_cnt, rx, word;
    logic [29:0] words_left;
    logic [4:0]  bit_cnt;
    logic [39:0] hdr;
    logic        last_bit;
    // serial bytes arrive MSB first; the first byte lands in the low byte of the RAM word
    assign word = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    always_comb last_bit = bit_cnt == (state == ADDR ? 5'd23 : state == READ ? 5'd31 : 5'd7);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= WAIT_POWER;
            wait_cnt         <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            error            <= 1'b0;
            error_address    <= '0;
            ramio_enable     <= 1'b0;
            ramio_write_type <= '0;
            ramio_read_type  <= '0;
            ramio_address    <= '0;
            ramio_data_in    <= '0;
            flash_clk        <= 1'b0;
            flash_mosi       <= 1'b0;
            flash_cs         <= 1'b1;
            addr             <= '0;
            words_left       <= '0;
            div_cnt          <= '0;
            bit_cnt          <= '0;
            hdr              <= '0;
            rx               <= '0;
        end else begin
            case (state)
                WAIT_POWER: begin
                    if (wait_cnt == STARTUP_WAIT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                IDLE: begin
                    if (start) begin
                        done       <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        flash_cs   <= 1'b0;
                        words_left <= WORDS;
                        addr       <= RAM_ADDRESS;
                        hdr        <= {CMD_BYTE, FLASH_ADDRESS, 8'h00};
                        flash_mosi <= CMD_BYTE[7];
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= CMD;
                    end
                end
                CMD, ADDR, DUMMY, READ: begin
                    // one SPI bit: SCK low for SCK_DIV cycles, then high for SCK_DIV cycles
                    if (div_cnt != SCK_DIV - 1) begin
                        div_cnt <= div_cnt + 32'd1;
                    end else begin
                        div_cnt   <= '0;
                        flash_clk <= !flash_clk;
                        if (!flash_clk) begin
                            if (state == READ) rx <= {rx[30:0], flash_miso};
                        end else begin
                            hdr        <= hdr << 1;
                            flash_mosi <= hdr[38];
                            bit_cnt    <= last_bit ? 5'd0 : bit_cnt + 5'd1;
                            if (last_bit)
                                state <= state == CMD ? ADDR :
                                         state == ADDR ? (FAST_READ ? DUMMY : READ) :
                                         state == DUMMY ? READ : WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (!ramio_busy) begin
                        ramio_enable     <= 1'b1;
                        ramio_write_type <= 2'b11;
                        ramio_read_type  <= '0;
                        ramio_address    <= addr;
                        ramio_data_in    <= word;
                        state            <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (!ramio_busy) begin
                        ramio_enable     <= 1'b0;
                        ramio_write_type <= '0;
                        if (VERIFY) begin
                            state <= VF_REQ;
                        end else begin
                            addr       <= addr + 32'd4;
                            words_left <= words_left - 30'd1;
                            state      <= words_left == 30'd1 ? FINISH : READ;
                        end
                    end
                end
                VF_REQ: begin
                    if (!ramio_busy) begin
                        ramio_enable     <= 1'b1;
                        ramio_read_type  <= 3'b011;
                        ramio_write_type <= '0;
                        state            <= VF_WAIT;
                    end
                end
                VF_WAIT: begin
                    if (ramio_data_out_ready) begin
                        ramio_enable    <= 1'b0;
                        ramio_read_type <= '0;
                        if (ramio_data_out != ramio_data_in) begin
                            error         <= 1'b1;
                            error_address <= ramio_address;
                            flash_cs      <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            addr       <= addr + 32'd4;
                            words_left <= words_left - 30'd1;
                            state      <= words_left == 30'd1 ? FINISH : READ;
                        end
                    end
                end
                FINISH: begin
                    flash_cs <= 1'b1;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= WAIT_POWER;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: two loader instances (plain read / fast read with divider) against
// behavioural SPI flash and RAM models, with a write scoreboard and a table of copy scenarios.
module tb_flash_loader;
    localparam int N = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start [N], stall [N], corrupt [N];
    logic busy [N], done [N], error [N], ram_en [N], sck [N], mosi [N], cs [N];
    logic [31:0] err_addr [N], ram_addr [N], ram_din [N];
    logic [1:0] wt [N];
    logic [2:0] rt [N];
    logic [39:0] hdr_cap [N];
    int fcnt [N];
    logic [63:0] sbq [$];
    int n_cmp = 0, n_fail = 0, phase_bad = 0, stall_en = 0, stall_pin = 0;
    bit stall_mon = 0, stall_late = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int HB = g ? 40 : 32;
        logic [39:0] cap;
        int cnt;
        logic miso_l, rdy_l;
        logic [31:0] last_l;
        logic [23:0] fa;
        logic [7:0] fb;
        flash_loader #(
            .STARTUP_WAIT(10), .FLASH_ADDRESS(24'h000100), .RAM_ADDRESS(32'h40),
            .TRANSFER_BYTES_NUM(32'd16), .SCK_DIV(g ? 3 : 1), .FAST_READ(g == 1), .VERIFY(g == 0)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]), .done(done[g]),
            .error(error[g]), .error_address(err_addr[g]), .ramio_enable(ram_en[g]),
            .ramio_write_type(wt[g]), .ramio_read_type(rt[g]), .ramio_address(ram_addr[g]),
            .ramio_data_in(ram_din[g]),
            .ramio_data_out((corrupt[g] && ram_addr[g] == 32'h48) ? 32'hDEADBEEF : last_l),
            .ramio_data_out_ready(rdy_l), .ramio_busy(stall[g]), .flash_clk(sck[g]),
            .flash_mosi(mosi[g]), .flash_cs(cs[g]), .flash_miso(miso_l)
        );
        assign fa = HB == 40 ? cap[31:8] : cap[23:0];
        assign hdr_cap[g] = cap;
        assign fcnt[g] = cnt;
        // flash: header captured on SCK rise, data byte (addr+i)&0xFF driven MSB first on SCK fall
        always @(posedge sck[g] or posedge cs[g])
            if (cs[g]) cnt <= 0;
            else begin
                if (cnt < HB) cap <= cnt == 0 ? {39'd0, mosi[g]} : {cap[38:0], mosi[g]};
                cnt <= cnt + 1;
            end
        always @(negedge sck[g])
            if (cnt >= HB) begin
                fb = 8'(fa) + 8'((cnt - HB) / 8);
                miso_l <= fb[7 - (cnt - HB) % 8];
            end
        always @(posedge clk) begin
            rdy_l <= ram_en[g] && rt[g] == 3'b011 && !rdy_l;
            if (ram_en[g] && wt[g] == 2'b11) last_l <= ram_din[g];
        end
    end

    typedef struct {
        int g;
        bit corrupt, stall, rst_mid;
        int nw;
        bit e_done, e_err;
        logic [31:0] e_eaddr;
    } vec_t;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void push_words(int n);
        for (int i = 0; i < n; i++)
            sbq.push_back({32'h40 + 32'(4 * i), 8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
    endfunction

    task automatic pulse(int g);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_busy(int g, logic val, int lim, string nm);
        for (int i = 0; i < lim && busy[g] !== val; i++) @(negedge clk);
        check(nm, busy[g], val);
    endtask

    task automatic wait_bits(int g, int n);
        for (int i = 0; i < 3000 && fcnt[g] < n; i++) @(negedge clk);
        check("flash bit wait", fcnt[g] >= n, 1);
    endtask

    task automatic monitor();
        logic pen [N];
        logic psck [N];
        int plen [N];
        logic [63:0] e;
        for (int g = 0; g < N; g++) begin
            pen[g] = 0;
            psck[g] = 0;
            plen[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                if (ram_en[g] === 1'b1 && pen[g] !== 1'b1 && wt[g] === 2'b11) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected write: inst %0d addr %h data %h, none expected", g, ram_addr[g], ram_din[g]);
                    end else begin
                        e = sbq.pop_front();
                        check("write addr/data", {ram_addr[g], ram_din[g]}, e);
                    end
                end
                pen[g] = ram_en[g];
                if (cs[g] !== 1'b0) plen[g] = 0;
                else if (sck[g] !== psck[g]) begin
                    if (psck[g] ? plen[g] != (g ? 3 : 1) : plen[g] < (g ? 3 : 1)) phase_bad++;
                    plen[g] = 1;
                end else plen[g]++;
                psck[g] = sck[g];
                if (stall_mon && g == 0) begin
                    if (ram_en[g] !== 1'b0) stall_en++;
                    if (stall_late && (sck[g] !== 1'b0 || cs[g] !== 1'b0)) stall_pin++;
                end
            end
        end
    endtask

    initial begin
        vec_t tv [5];
        int k;
        tv[0] = '{0, 0, 0, 0, 4, 1, 0, 32'h0};
        tv[1] = '{1, 0, 0, 0, 4, 1, 0, 32'h0};
        tv[2] = '{0, 0, 1, 0, 4, 1, 0, 32'h0};
        tv[3] = '{0, 1, 0, 0, 3, 0, 1, 32'h48};
        tv[4] = '{0, 0, 0, 1, 4, 1, 0, 32'h0};
        for (int i = 0; i < N; i++) begin
            start[i] = 0;
            stall[i] = 0;
            corrupt[i] = 0;
        end
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check("reset flags busy/done/err/en/sck/mosi/cs", {busy[0], done[0], error[0], ram_en[0], sck[0], mosi[0], cs[0]}, 7'b1000001);
        check("reset types", {wt[0], rt[0]}, 0);
        check("reset error_address", err_addr[0], 0);
        check("reset ramio_address", ram_addr[0], 0);
        check("reset ramio_data_in", ram_din[0], 0);
        rst_n = 1'b1;
        for (int v = 0; v < 5; v++) begin
            k = tv[v].g;
            wait_busy(k, 1'b0, 300, "ready");
            corrupt[k] = tv[v].corrupt;
            phase_bad = 0;
            push_words(tv[v].nw);
            pulse(k);
            if (tv[v].rst_mid) begin
                wait_bits(k, 68);
                rst_n = 1'b0;
                @(negedge clk);
                check("mid reset busy/cs/en/sck/done", {busy[k], cs[k], ram_en[k], sck[k], done[k]}, 5'b11000);
                rst_n = 1'b1;
                sbq.delete();
                repeat (8) @(negedge clk);
                check("power wait restarted", busy[k], 1'b1);
                wait_busy(k, 1'b0, 300, "ready after reset");
                push_words(4);
                pulse(k);
            end
            if (tv[v].stall) begin
                wait_bits(k, 92);
                stall[k] = 1'b1;
                stall_en = 0;
                stall_pin = 0;
                stall_mon = 1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    stall_late = i >= 10;
                end
                stall_mon = 0;
                stall_late = 0;
                stall[k] = 1'b0;
                check("stall enable held low", stall_en, 0);
                check("stall sck/cs held low", stall_pin, 0);
            end
            wait_busy(k, 1'b0, 3000, "copy complete");
            check("done", done[k], tv[v].e_done);
            check("error", error[k], tv[v].e_err);
            check("error_address", err_addr[k], tv[v].e_eaddr);
            check("cs released", cs[k], 1'b1);
            check("writes outstanding", sbq.size(), 0);
            check("spi header", hdr_cap[k], k ? 40'h0B00010000 : 40'h0003000100);
            check("sck phase violations", phase_bad, 0);
            sbq.delete();
        end
        corrupt[0] = 0;
        wait_busy(0, 1'b0, 300, "ready rules");
        push_words(4);
        pulse(0);
        repeat (20) @(negedge clk);
        pulse(0);
        wait_busy(0, 1'b0, 3000, "rules copy complete");
        check("rules done", done[0], 1'b1);
        check("rules writes outstanding", sbq.size(), 0);
        repeat (5) @(negedge clk);
        check("busy start not queued", busy[0], 1'b0);
        push_words(4);
        pulse(0);
        check("restart done/busy/cs", {done[0], busy[0], cs[0]}, 3'b010);
        wait_busy(0, 1'b0, 3000, "repeat copy complete");
        check("repeat done", done[0], 1'b1);
        check("repeat writes outstanding", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
